// File: rtl/address_decoder.sv
// ============================================================================
// Module   : address_decoder
// Brief    : 68000 bus front-end: clock generator, CPU/DMA mux, chip-select decode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module address_decoder #(
  parameter int LOCK_CYCLES = 4
) (
  input  logic        refclk,
  input  logic        rst,
  output logic        outclk_0,
  output logic        outclk_1,
  output logic        outclk_2,
  output logic        outclk_3,
  output logic        locked,
  input  logic        CPU_DMA_Select,
  input  logic        CPU_AS_L,
  input  logic        CPU_UDS_L,
  input  logic        CPU_LDS_L,
  input  logic        CPU_RW,
  input  logic [31:0] CPU_Address,
  input  logic [15:0] CPU_DataBusOut,
  input  logic        DMA_AS_L,
  input  logic        DMA_UDS_L,
  input  logic        DMA_LDS_L,
  input  logic        DMA_RW,
  input  logic [31:0] DMA_Address,
  input  logic [15:0] DMA_DataBusOut,
  output logic        AS_L,
  output logic        UDS_L,
  output logic        LDS_L,
  output logic        RW,
  output logic [31:0] AddressOut,
  output logic [15:0] DataOut,
  output logic        OnChipRomSelect_H,
  output logic        OnChipRamSelect_H,
  output logic        DramSelect_H,
  output logic        IOSelect_H,
  output logic        CanBusSelect_H,
  output logic        VoiceControl_H,
  output logic        OffBoardMemory_H,
  output logic        GraphicsCS_L,
  output logic        wrencursor,
  output logic        DMASelect_L
);

  localparam int CNT_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LOCK_COUNT = CNT_W'(LOCK_CYCLES);

  logic             r_clk_div;
  logic [CNT_W-1:0] r_lock_cnt;

  // --------------------------------------------------------------------------
  // Clock generation
  // --------------------------------------------------------------------------
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_clk_div  <= 1'b0;
      r_lock_cnt <= '0;
    end else begin
      r_clk_div <= ~r_clk_div;
      if (r_lock_cnt != C_LOCK_COUNT)
        r_lock_cnt <= r_lock_cnt + 1'b1;
    end
  end

  assign outclk_0 = r_clk_div;
  assign outclk_1 = r_clk_div;
  assign outclk_2 = refclk;
  assign outclk_3 = ~refclk;
  assign locked   = (r_lock_cnt == C_LOCK_COUNT);

  // --------------------------------------------------------------------------
  // Bus-master mux
  // --------------------------------------------------------------------------
  assign AS_L       = CPU_DMA_Select ? CPU_AS_L       : DMA_AS_L;
  assign UDS_L      = CPU_DMA_Select ? CPU_UDS_L      : DMA_UDS_L;
  assign LDS_L      = CPU_DMA_Select ? CPU_LDS_L      : DMA_LDS_L;
  assign RW         = CPU_DMA_Select ? CPU_RW         : DMA_RW;
  assign AddressOut = CPU_DMA_Select ? CPU_Address    : DMA_Address;
  assign DataOut    = CPU_DMA_Select ? CPU_DataBusOut : DMA_DataBusOut;

  // --------------------------------------------------------------------------
  // Address decode on the muxed address
  // --------------------------------------------------------------------------
  logic w_rom, w_io, w_can, w_ram, w_dram, w_gfx, w_cursor_region, w_voice, w_dma;

  assign w_rom           = (AddressOut[31:15] == 17'h0);
  assign w_io            = (AddressOut[31:16] == 16'h0040);
  assign w_can           = (AddressOut[31:20] == 12'h005);
  assign w_ram           = (AddressOut[31:18] == 14'h0200);
  assign w_dram          = (AddressOut[31:26] == 6'b111100);
  assign w_gfx           = (AddressOut[31:13] == 19'h7F800);
  assign w_cursor_region = (AddressOut[31:3]  == 29'h1FE02000);
  assign w_voice         = (AddressOut[31:16] == 16'hFF02);
  assign w_dma           = (AddressOut[31:16] == 16'hFF04);

  assign OnChipRomSelect_H = w_rom;
  assign IOSelect_H        = w_io;
  assign CanBusSelect_H    = w_can;
  assign OnChipRamSelect_H = w_ram;
  assign DramSelect_H      = w_dram;
  assign GraphicsCS_L      = w_gfx;
  assign VoiceControl_H    = w_voice;
  assign DMASelect_L       = ~w_dma;
  // Cursor writes are strobe-qualified; the region alone still blocks off-board.
  assign wrencursor        = w_cursor_region & ~AS_L & ~RW;
  assign OffBoardMemory_H  = ~(w_rom | w_io | w_can | w_ram | w_dram | w_gfx |
                               w_cursor_region | w_voice | w_dma);

endmodule

`default_nettype wire

// File: tb/tb_address_decoder.sv
// ============================================================================
// Module   : tb_address_decoder
// Brief    : Directed self-checking bench for address_decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_address_decoder;

  logic        refclk = 1'b0;
  logic        rst;
  logic        outclk_0, outclk_1, outclk_2, outclk_3, locked;
  logic        CPU_DMA_Select;
  logic        CPU_AS_L, CPU_UDS_L, CPU_LDS_L, CPU_RW;
  logic [31:0] CPU_Address;
  logic [15:0] CPU_DataBusOut;
  logic        DMA_AS_L, DMA_UDS_L, DMA_LDS_L, DMA_RW;
  logic [31:0] DMA_Address;
  logic [15:0] DMA_DataBusOut;
  logic        AS_L, UDS_L, LDS_L, RW;
  logic [31:0] AddressOut;
  logic [15:0] DataOut;
  logic        OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H, IOSelect_H;
  logic        CanBusSelect_H, VoiceControl_H, OffBoardMemory_H;
  logic        GraphicsCS_L, wrencursor, DMASelect_L;

  int n_checks = 0;
  int n_errors = 0;

  // Active-sense select vector, one bit per region
  localparam logic [9:0] S_NONE = 10'b0000000000;
  localparam logic [9:0] S_ROM  = 10'b1000000000;
  localparam logic [9:0] S_RAM  = 10'b0100000000;
  localparam logic [9:0] S_DRAM = 10'b0010000000;
  localparam logic [9:0] S_IO   = 10'b0001000000;
  localparam logic [9:0] S_CAN  = 10'b0000100000;
  localparam logic [9:0] S_GFX  = 10'b0000010000;
  localparam logic [9:0] S_CUR  = 10'b0000001000;
  localparam logic [9:0] S_VOC  = 10'b0000000100;
  localparam logic [9:0] S_DMA  = 10'b0000000010;
  localparam logic [9:0] S_OFF  = 10'b0000000001;

  address_decoder #(.LOCK_CYCLES(4)) dut (
    .refclk(refclk), .rst(rst),
    .outclk_0(outclk_0), .outclk_1(outclk_1), .outclk_2(outclk_2),
    .outclk_3(outclk_3), .locked(locked),
    .CPU_DMA_Select(CPU_DMA_Select),
    .CPU_AS_L(CPU_AS_L), .CPU_UDS_L(CPU_UDS_L), .CPU_LDS_L(CPU_LDS_L),
    .CPU_RW(CPU_RW), .CPU_Address(CPU_Address), .CPU_DataBusOut(CPU_DataBusOut),
    .DMA_AS_L(DMA_AS_L), .DMA_UDS_L(DMA_UDS_L), .DMA_LDS_L(DMA_LDS_L),
    .DMA_RW(DMA_RW), .DMA_Address(DMA_Address), .DMA_DataBusOut(DMA_DataBusOut),
    .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L), .RW(RW),
    .AddressOut(AddressOut), .DataOut(DataOut),
    .OnChipRomSelect_H(OnChipRomSelect_H), .OnChipRamSelect_H(OnChipRamSelect_H),
    .DramSelect_H(DramSelect_H), .IOSelect_H(IOSelect_H),
    .CanBusSelect_H(CanBusSelect_H), .VoiceControl_H(VoiceControl_H),
    .OffBoardMemory_H(OffBoardMemory_H), .GraphicsCS_L(GraphicsCS_L),
    .wrencursor(wrencursor), .DMASelect_L(DMASelect_L)
  );

  always #10 refclk = ~refclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] sel_vec();
    return {OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H, IOSelect_H,
            CanBusSelect_H, GraphicsCS_L, wrencursor, VoiceControl_H,
            ~DMASelect_L, OffBoardMemory_H};
  endfunction

  task automatic decode(input string tag, input logic [31:0] addr,
                        input logic as_l, input logic rw, input logic [9:0] exp);
    @(negedge refclk);
    CPU_DMA_Select = 1'b1;
    CPU_Address    = addr;
    CPU_AS_L       = as_l;
    CPU_RW         = rw;
    #1;
    check(tag, {22'h0, sel_vec()}, {22'h0, exp});
  endtask

  initial begin
    rst = 1'b1;
    CPU_DMA_Select = 1'b1;
    CPU_AS_L = 1'b0; CPU_UDS_L = 1'b1; CPU_LDS_L = 1'b0; CPU_RW = 1'b1;
    CPU_Address = 32'h0000_1234; CPU_DataBusOut = 16'hAAAA;
    DMA_AS_L = 1'b1; DMA_UDS_L = 1'b0; DMA_LDS_L = 1'b1; DMA_RW = 1'b0;
    DMA_Address = 32'h0800_0000; DMA_DataBusOut = 16'h5555;

    // Reset state
    repeat (2) @(posedge refclk);
    #1;
    check("rst_outclk0", {31'h0, outclk_0}, 32'd0);
    check("rst_locked",  {31'h0, locked},   32'd0);

    // Run five posedges: outclk_0 high, locked set
    @(negedge refclk);
    rst = 1'b0;
    repeat (5) @(posedge refclk);
    #1;
    check("pre_rst_outclk0", {31'h0, outclk_0}, 32'd1);
    check("pre_rst_locked",  {31'h0, locked},   32'd1);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_outclk0", {31'h0, outclk_0}, 32'd0);
    check("async_outclk1", {31'h0, outclk_1}, 32'd0);
    check("async_locked",  {31'h0, locked},   32'd0);

    // Release and step posedge by posedge
    @(negedge refclk);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge refclk);
      #1;
      check($sformatf("outclk0_p%0d", i), {31'h0, outclk_0}, {31'h0, 1'(i % 2)});
      check($sformatf("outclk1_p%0d", i), {31'h0, outclk_1}, {31'h0, 1'(i % 2)});
      check($sformatf("locked_p%0d", i),  {31'h0, locked},   {31'h0, 1'(i >= 4)});
    end
    check("outclk2_hi", {31'h0, outclk_2}, 32'd1);
    check("outclk3_lo", {31'h0, outclk_3}, 32'd0);
    @(negedge refclk);
    #1;
    check("outclk2_lo", {31'h0, outclk_2}, 32'd0);
    check("outclk3_hi", {31'h0, outclk_3}, 32'd1);

    // Mux: CPU then DMA
    CPU_DMA_Select = 1'b1;
    #1;
    check("mux_cpu_addr",    AddressOut, 32'h0000_1234);
    check("mux_cpu_data",    {16'h0, DataOut}, 32'h0000_AAAA);
    check("mux_cpu_strobes", {28'h0, AS_L, UDS_L, LDS_L, RW}, 32'h5);
    check("mux_cpu_sel",     {22'h0, sel_vec()}, {22'h0, S_ROM});
    CPU_DMA_Select = 1'b0;
    #1;
    check("mux_dma_addr",    AddressOut, 32'h0800_0000);
    check("mux_dma_data",    {16'h0, DataOut}, 32'h0000_5555);
    check("mux_dma_strobes", {28'h0, AS_L, UDS_L, LDS_L, RW}, 32'hA);
    check("mux_dma_sel",     {22'h0, sel_vec()}, {22'h0, S_RAM});

    // Decode boundaries and regions
    decode("rom_top",      32'h0000_7FFF, 1'b1, 1'b1, S_ROM);
    decode("rom_above",    32'h0000_8000, 1'b1, 1'b1, S_OFF);
    decode("ram_top",      32'h0803_FFFF, 1'b1, 1'b1, S_RAM);
    decode("ram_above",    32'h0804_0000, 1'b1, 1'b1, S_OFF);
    decode("ram_below",    32'h07FF_FFFF, 1'b1, 1'b1, S_OFF);
    decode("dram_top",     32'hF3FF_FFFF, 1'b1, 1'b1, S_DRAM);
    decode("dram_above",   32'hF400_0000, 1'b1, 1'b1, S_OFF);
    decode("dram_base",    32'hF000_0000, 1'b1, 1'b1, S_DRAM);
    decode("gfx_in",       32'hFF00_1FFE, 1'b1, 1'b1, S_GFX);
    decode("gfx_above",    32'hFF00_2000, 1'b1, 1'b1, S_OFF);
    decode("cursor_wr",    32'hFF01_0002, 1'b0, 1'b0, S_CUR);
    decode("cursor_rd",    32'hFF01_0002, 1'b0, 1'b1, S_NONE);
    decode("cursor_idle",  32'hFF01_0002, 1'b1, 1'b0, S_NONE);
    decode("cursor_above", 32'hFF01_0008, 1'b0, 1'b0, S_OFF);
    decode("io",           32'h0040_0010, 1'b1, 1'b1, S_IO);
    decode("can",          32'h0050_0000, 1'b1, 1'b1, S_CAN);
    decode("voice",        32'hFF02_0000, 1'b1, 1'b1, S_VOC);
    decode("dma_reg",      32'hFF04_0000, 1'b1, 1'b1, S_DMA);
    decode("colour_reg",   32'hFF03_0000, 1'b1, 1'b1, S_OFF);

    // Decode is independent of reset
    rst = 1'b1;
    decode("rst_decode",   32'h0040_0010, 1'b1, 1'b1, S_IO);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
